mfi_check_sequencer: RTL
========================

MFI_CHECK_SEQUENCER -- requirements
Module: mfi_check_sequencer

Interface
REQ-001 SHALL have parameter WARMUP, default 4: minimum retirements observed before the check window may arm.
REQ-002 SHALL have parameter TIMEOUT, default 64: cycles without a retirement, while armed, before the sequencer aborts.
REQ-003 SHALL have parameter CNT_W, default 16: width of the retirement counter.
REQ-004 SHALL have port clock, input, 1: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port resetn, input, 1: synchronous, active-low reset.
REQ-006 SHALL have port mfi_valid, input, 1: a retirement occurs this cycle.
REQ-007 SHALL have port mfi_order, input, 32: order of the retiring instruction.
REQ-008 SHALL have port trig_order, input, 32: target order for the check, held constant after reset.
REQ-009 SHALL have port check, output, 1: check strobe to the downstream checkers.
REQ-010 SHALL have port armed, output, 1: the sequencer is in ARMED.
REQ-011 SHALL have port done, output, 1: sticky; the check was issued.
REQ-012 SHALL have port abort, output, 1: sticky; the sequence was abandoned.
REQ-013 SHALL have port order_err, output, 1: sticky; a non-consecutive retirement order was observed.
REQ-014 SHALL have port retire_cnt, output, CNT_W: count of observed retirements.

Function
REQ-015 SHALL implement the states IDLE, WARMUP, ARMED, CHECK, DONE and ABORT.
REQ-016 IDLE->WARMUP: on the first cycle after reset deasserts.
REQ-017 In WARMUP, each mfi_valid SHALL increment retire_cnt; go to ARMED in the cycle after retire_cnt reaches WARMUP.
REQ-018 ARMED->CHECK: when mfi_valid && mfi_order==trig_order-1, i.e. the check targets the next retirement.
REQ-019 In CHECK, check SHALL be 1 for exactly the cycles in CHECK; leave CHECK the cycle after the first mfi_valid observed in CHECK, going to DONE.
REQ-020 done and abort SHALL assert in the first cycle of DONE and ABORT respectively; DONE and ABORT are terminal until reset.
REQ-021 If trig_order-1 is retired while in WARMUP, the sequencer SHALL go to ABORT; the target has been missed.
REQ-022 While in ARMED, if mfi_valid && mfi_order >= trig_order, the sequencer SHALL go to ABORT.
REQ-023 Order tracking: after the first retirement, every mfi_valid with mfi_order != previous+1 SHALL set order_err the next cycle; order_err has no effect on state.
REQ-024 The previous-order register SHALL compare with 32-bit wrap-around: 0xFFFFFFFF+1 == 0.
REQ-025 retire_cnt SHALL saturate at 2^CNT_W-1 and count in every state except IDLE.
REQ-026 If a warmup-complete condition and a matching retirement occur in the same cycle, the retirement is counted and the transition to ARMED wins.
REQ-027 All outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-028 With resetn==0 at a clock edge: state=IDLE; check, armed, done, abort, order_err=0; retire_cnt=0; order tracker invalid.
REQ-029 A reset in any state, including mid-CHECK, SHALL return to IDLE on that edge with check dropped.

Configuration
REQ-030 MFI_CHECK_TIMEOUT_EN defined: in ARMED or CHECK, a cycle counter reloads on mfi_valid; reaching TIMEOUT consecutive cycles without mfi_valid SHALL go to ABORT.
REQ-031 MFI_CHECK_TIMEOUT_EN undefined: no timeout counter; ARMED and CHECK wait indefinitely; TIMEOUT is ignored.

Verification
REQ-032 Reset, then retire orders 0..9 each cycle, trig_order=7 -> armed set after retire 3; check high for the cycle retiring order 7; done=1 next; retire_cnt=10 at end.
REQ-033 trig_order=2, WARMUP=4, orders 0..5 -> abort=1 after order 1 retires; check never asserted.
REQ-034 Orders 0,1,2,4 -> order_err=1 the cycle after order 4; state sequence unchanged.
REQ-035 Macro defined, TIMEOUT=8, armed with no retirements for 8 cycles -> abort=1; macro undefined -> remains armed.
REQ-036 resetn low during CHECK -> next cycle check=0, state IDLE, all sticky flags cleared.
REQ-037 Orders 0xFFFFFFFE, 0xFFFFFFFF, 0x0 -> order_err stays 0.

Source files
------------

// File: rtl/mfi_check_sequencer.sv
// rtl/mfi_check_sequencer.sv - retirement-driven check sequencer (optional timeout: MFI_CHECK_TIMEOUT_EN)
module mfi_check_sequencer #(
    parameter int WARMUP  = 4,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             mfi_valid,
    input  logic [31:0]      mfi_order,
    input  logic [31:0]      trig_order,
    output logic             check,
    output logic             armed,
    output logic             done,
    output logic             abort,
    output logic             order_err,
    output logic [CNT_W-1:0] retire_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WARMUP = 3'd1,
        S_ARMED  = 3'd2,
        S_CHECK  = 3'd3,
        S_DONE   = 3'd4,
        S_ABORT  = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] WARMUP_C = CNT_W'(WARMUP);

    // A zero timeout would abort on the very first idle cycle; reject it at elaboration
    if (TIMEOUT < 1) begin : g_timeout_range
        $error("TIMEOUT must be at least 1");
    end

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;
    logic [31:0]       prev_order_q, prev_order_d;
    logic              prev_valid_q, prev_valid_d;
    logic              check_q, check_d;
    logic              armed_q, armed_d;
    logic              done_q, done_d;
    logic              abort_q, abort_d;
    logic              order_err_q, order_err_d;
    logic [31:0]       trig_m1;
    logic              timeout_hit;

    // The check fires on the retirement after trig_order-1; 32-bit wrap is intended
    assign trig_m1 = trig_order - 32'd1;

`ifdef MFI_CHECK_TIMEOUT_EN
    localparam int                TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);

    logic [TMO_W-1:0] idle_cnt_q, idle_cnt_d;

    // Count consecutive retirement-free cycles while waiting in ARMED/CHECK
    always_comb begin
        idle_cnt_d  = '0;
        timeout_hit = 1'b0;
        if ((state_q == S_ARMED || state_q == S_CHECK) && !mfi_valid) begin
            if (idle_cnt_q == TMO_LAST) begin
                timeout_hit = 1'b1;
            end else begin
                idle_cnt_d = idle_cnt_q + TMO_W'(1);
            end
        end
    end

    // Idle-cycle counter register
    always_ff @(posedge clock) begin
        if (!resetn) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Saturating retirement counter, frozen only while in IDLE
    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (state_q != S_IDLE && mfi_valid && retire_cnt_q != CNT_MAX) begin
            retire_cnt_d = retire_cnt_q + CNT_W'(1);
        end
    end

    // Order tracker: flag any retirement that is not previous+1 (mod 2^32)
    always_comb begin
        prev_order_d = prev_order_q;
        prev_valid_d = prev_valid_q;
        order_err_d  = order_err_q;
        if (mfi_valid) begin
            if (prev_valid_q && mfi_order != (prev_order_q + 32'd1)) begin
                order_err_d = 1'b1;
            end
            prev_order_d = mfi_order;
            prev_valid_d = 1'b1;
        end
    end

    // Next-state logic; ARMED entry beats a same-cycle missed-target abort in WARMUP
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_WARMUP;
            end
            S_WARMUP: begin
                if (retire_cnt_d >= WARMUP_C) begin
                    state_d = S_ARMED;
                end else if (mfi_valid && mfi_order == trig_m1) begin
                    state_d = S_ABORT;
                end
            end
            S_ARMED: begin
                if (timeout_hit) begin
                    state_d = S_ABORT;
                end else if (mfi_valid && mfi_order == trig_m1) begin
                    state_d = S_CHECK;
                end else if (mfi_valid && mfi_order >= trig_order) begin
                    state_d = S_ABORT;
                end
            end
            S_CHECK: begin
                if (mfi_valid) begin
                    state_d = S_DONE;
                end else if (timeout_hit) begin
                    state_d = S_ABORT;
                end
            end
            S_DONE:  state_d = S_DONE;
            S_ABORT: state_d = S_ABORT;
            default: state_d = S_IDLE;
        endcase
    end

    // Output flops follow the next state so they line up with state_q
    always_comb begin
        check_d = (state_d == S_CHECK);
        armed_d = (state_d == S_ARMED);
        done_d  = done_q  | (state_d == S_DONE);
        abort_d = abort_q | (state_d == S_ABORT);
    end

    // State and output registers
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            retire_cnt_q <= '0;
            prev_order_q <= '0;
            prev_valid_q <= 1'b0;
            check_q      <= 1'b0;
            armed_q      <= 1'b0;
            done_q       <= 1'b0;
            abort_q      <= 1'b0;
            order_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            retire_cnt_q <= retire_cnt_d;
            prev_order_q <= prev_order_d;
            prev_valid_q <= prev_valid_d;
            check_q      <= check_d;
            armed_q      <= armed_d;
            done_q       <= done_d;
            abort_q      <= abort_d;
            order_err_q  <= order_err_d;
        end
    end

    assign check      = check_q;
    assign armed      = armed_q;
    assign done       = done_q;
    assign abort      = abort_q;
    assign order_err  = order_err_q;
    assign retire_cnt = retire_cnt_q;

endmodule
